// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM array.
package data_mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int WSTRB_W    = MEM_DATA_W / 8;
    localparam int WORD_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with per-byte write strobes and registered read data.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [WSTRB_W-1:0]    wstrb,
    input  logic [MEM_DATA_W-1:0] wdata,
    output logic [MEM_DATA_W-1:0] rdata
);

    logic [MEM_DATA_W-1:0] mem [DEPTH];

    // Read data only updates on a load, so it holds while the response is stalled.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WSTRB_W; i++) begin
                    if (wstrb[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, response held under backpressure.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid-side holds its payload until then.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [WSTRB_W-1:0] req_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output state_t             state_dbg
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 lat_we;
    logic [ADDR_W-1:0]    lat_addr;
    logic [DATA_W-1:0]    lat_wdata;
    logic [WSTRB_W-1:0]   lat_wstrb;
    logic                 rsp_load;
    logic [DATA_W-1:0]    ram_rdata;
    logic [ADDR_W-WORD_OFF_W-1:0] word_addr;
    logic                 acc_err;
    logic                 do_access;

    assign word_addr = lat_addr[ADDR_W-1:WORD_OFF_W];
    assign acc_err   = (|lat_addr[WORD_OFF_W-1:0]) |
                       ({{WORD_OFF_W{1'b0}}, word_addr} >= ADDR_W'(DEPTH));
    assign do_access = (state == WAIT) && (cnt == '0);

    data_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (do_access & ~acc_err),
        .we    (lat_we),
        .idx   (word_addr[IDX_W-1:0]),
        .wstrb (lat_wstrb),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    // Load data is gated by a registered flag so stores and errors return zero.
    assign rsp_rdata = rsp_load ? ram_rdata : '0;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        cnt       <= CNT_W'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_load  <= ~lat_we & ~acc_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_load  <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomised checks of the data-memory responder against a byte-lane memory model.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    state_t            state_dbg;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] mdl[int];

    data_mem_responder #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: returns {err, rdata} and applies stores.
    function automatic logic [32:0] model_access(input logic we, input logic [31:0] addr,
                                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] word;
        int          idx;
        if (addr[1:0] != 2'b00 || addr[31:2] >= 30'(DEPTH)) return {1'b1, 32'h0};
        idx  = int'(addr[31:2]);
        word = mdl.exists(idx) ? mdl[idx] : 32'h0;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) word[8*i +: 8] = wdata[8*i +: 8];
            mdl[idx] = word;
            return {1'b0, 32'h0};
        end
        return {1'b0, word};
    endfunction

    // driver + response checker; stall = cycles rsp_ready is held low once rsp_valid rises
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int stall);
        int          n;
        logic [32:0] exp;
        logic [31:0] held_data;
        logic        held_err;
        @(negedge clk);
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_timeout"}, 64'(n < 50), 64'd1);
        exp_q.push_back(model_access(we, addr, wdata, wstrb));
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LATENCY));
        held_data = rsp_rdata;
        held_err  = rsp_err;
        for (int s = 0; s < stall; s++) begin
            check({tag, "_stall_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_stall_rdata"}, 64'(rsp_rdata), 64'(held_data));
            check({tag, "_stall_err"},   64'(rsp_err),   64'(held_err));
            check({tag, "_stall_rdy"},   64'(req_ready), 64'd0);
            @(negedge clk);
        end
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp[31:0]));
            check({tag, "_err"},   64'(rsp_err),   64'(exp[32]));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_post_rdy"},   64'(req_ready), 64'd1);
        check({tag, "_post_rdata"}, 64'(rsp_rdata), 64'd0);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;

        // reset then idle
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        check("release_req_ready", 64'(req_ready), 64'd1);
        check("release_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

        // store then load, partial store
        do_req("st_full",  1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req("ld_full",  1'b0, 32'h10, 32'h0,        4'h0, 0);
        do_req("st_part",  1'b1, 32'h10, 32'h00001234, 4'b0011, 0);
        do_req("ld_part",  1'b0, 32'h10, 32'h0,        4'h0, 0);
        check("ld_part_const", 64'(mdl[4]), 64'h00000000DEAD1234);
        do_req("st_nop",   1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
        do_req("ld_nop",   1'b0, 32'h10, 32'h0,        4'h0, 0);

        // errors
        do_req("st_w0",    1'b1, 32'h0,    32'h0BADF00D, 4'hF, 0);
        do_req("ld_mis",   1'b0, 32'h11,   32'h0,        4'h0, 0);
        do_req("st_oor",   1'b1, 32'h1000, 32'h55555555, 4'hF, 0);
        do_req("st_mis",   1'b1, 32'h2,    32'h77777777, 4'hF, 0);
        do_req("ld_w0",    1'b0, 32'h0,    32'h0,        4'h0, 0);
        do_req("ld_last",  1'b0, 32'hFFC,  32'h0,        4'h0, 0);

        // backpressure
        do_req("ld_bp",    1'b0, 32'h10,   32'h0,        4'h0, 5);
        do_req("err_bp",   1'b0, 32'h13,   32'h0,        4'h0, 3);

        // reset mid-operation: pending store must be abandoned
        do_req("st_w8",    1'b1, 32'h20, 32'h11223344, 4'hF, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_wait", 64'(state_dbg), 64'(WAIT));
        rst = 1'b0;
        #1;
        check_outputs_idle("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_stray_valid", 64'(rsp_valid), 64'd0);
        end
        do_req("ld_w8",    1'b0, 32'h20, 32'h0, 4'h0, 0);

        // random traffic over words 0..7
        for (int i = 0; i < 8; i++)
            do_req("rnd_init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 16; i++) begin
            logic        we;
            logic [31:0] addr;
            we   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 7) * 4) | 32'($urandom_range(0, 7) == 0 ? 1 : 0);
            do_req("rnd", we, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready request channel. It services the request from an internal word-organised RAM after a programmable latency, then returns the result over a valid/ready response channel with backpressure. Software-visible memory can therefore model wait states instead of a zero-latency combinational read.

Parameters:
DATA_W, 32, data word width in bits (fixed at 32; wstrb width is DATA_W/8)
ADDR_W, 32, byte-address width
DEPTH, 1024, number of DATA_W words in the array
LATENCY, 2, cycles from request acceptance to rsp_valid (legal range 1..15)

Ports:
clk        input   1       single clock, all state updates on rising edge
rst        input   1       reset, asynchronous assert, active-low (0 = reset)
req_valid  input   1       request present
req_ready  output  1       responder can accept a request
req_we     input   1       1 = store, 0 = load
req_addr   input   ADDR_W  byte address
req_wdata  input   DATA_W  store data
req_wstrb  input   4       byte enables for store; bit i enables byte lane i
rsp_valid  output  1       response present
rsp_ready  input   1       requester accepts the response
rsp_rdata  output  DATA_W  load data; 0 for stores and errors
rsp_err    output  1       misaligned or out-of-range access

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0, request latches cleared. RAM contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 from the first edge after rst is released.
  - On edge k where req_valid & req_ready, latch we, addr, wdata and wstrb, load counter=LATENCY-1, and go to WAIT.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - On the edge where counter==0, perform the access and go to RESP. That edge is k+LATENCY, so rsp_valid is high in the cycle after edge k+LATENCY.
  - LATENCY=1 means WAIT lasts exactly one cycle.
- Access, evaluated on the WAIT->RESP edge:
  - err = (addr[1:0]!=0) | (addr[ADDR_W-1:2] >= DEPTH).
  - On err: no RAM write, rsp_rdata=0, rsp_err=1.
  - Store without error: byte lanes with wstrb[i]=1 are written and other lanes keep their value; rsp_rdata=0, rsp_err=0. wstrb=0 is a legal no-op store.
  - Load without error: rsp_rdata = RAM word at addr[ADDR_W-1:2], including any store completed on an earlier transaction; rsp_err=0.
- RESP:
  - req_ready=0; rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready; the requester may stall any number of cycles.
  - On the handshake edge, go to IDLE and drive rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Requests presented while req_ready=0 are ignored; the requester must hold them until they are accepted.
- Minimum transaction spacing is LATENCY+2 cycles with rsp_ready held high. There is no overlap of requests.
- Reset asserted in WAIT abandons the pending store, leaving the RAM unchanged. Reset asserted in RESP drops the response.
- rsp_ready high while in IDLE or WAIT has no effect.

Decomposition:
- Shared package data_mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - WSTRB_W = DATA_W/8;
  - the WORD_OFF_W = 2 constant used for address alignment.
- One sub-module, data_mem_array: a single-port synchronous RAM of DEPTH x DATA_W with byte-strobe write, write-enable and word index inputs, and registered read data. The FSM, latches, counter and error check live in data_mem_responder.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release -> all outputs 0 during reset; req_ready=1 on the first edge after release; rsp_valid stays 0.
- Store then load, LATENCY=2, rsp_ready=1:
  - Store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF -> rsp_valid high 2 edges after acceptance with rsp_rdata=0, rsp_err=0.
  - Load addr=0x10 -> rsp_rdata=0xDEADBEEF.
- Partial store: from the previous state, store addr=0x10, wdata=0x00001234, wstrb=4'b0011; then load addr=0x10 -> rsp_rdata=0xDEAD1234.
- Errors:
  - Load addr=0x11 -> rsp_err=1, rsp_rdata=0.
  - Store addr=4*DEPTH=0x1000 -> rsp_err=1, and a subsequent load of word 0 is unchanged.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err are constant and req_ready=0 throughout; raising rsp_ready gives one handshake, then IDLE with req_ready=1 the next cycle.
- Reset mid-operation: store addr=0x20, wdata=0xCAFEF00D, then pull rst low during WAIT -> after reset, a load of addr=0x20 returns the prior contents, not 0xCAFEF00D; no stray rsp_valid.
